// File: rtl/nco_clock_pkg.sv
// Ratio constants for the clock-generation wrapper and the accumulator sizing helper.
package nco_clock_pkg;

  // CORE needs a ratio above 1, which an enable-pulse NCO cannot produce; kept for reference only.
  localparam int CORE_MUL    = 11;
  localparam int CORE_DIV    = 10;
  localparam int DISPLAY_MUL = 63;
  localparam int DISPLAY_DIV = 125;
  localparam int DPS_MUL     = 3072;
  localparam int DPS_DIV     = 3125;

  function automatic int accWidth(input int div);
    return $clog2(div) + 1;
  endfunction

endpackage

// File: rtl/nco_clock_gen_if.sv
// Restart input and enable/lock outputs of one NCO clock domain.
// The oC0 divided-clock signal exists only when NCO_CLK_OUT_EN is defined.
interface nco_clock_gen_if;
  logic iARESET;
  logic oC0_EN;
  logic oLOCKED;
`ifdef NCO_CLK_OUT_EN
  logic oC0;
`endif

  modport master (
    output iARESET,
`ifdef NCO_CLK_OUT_EN
    input  oC0,
`endif
    input  oC0_EN,
    input  oLOCKED
  );

  modport slave (
    input  iARESET,
`ifdef NCO_CLK_OUT_EN
    output oC0,
`endif
    output oC0_EN,
    output oLOCKED
  );
endinterface

// File: rtl/nco_lock_counter.sv
// PLL-style lock emulation: oLOCKED rises LOCK_CYCLES edges after reset or restart.
module nco_lock_counter #(
  parameter int LOCK_CYCLES = 16
) (
  input  logic iCLOCK,
  input  logic inRESET,
  input  logic iARESET,
  output logic oLOCKED
);

  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

  logic [CNT_W-1:0] lockCnt;

  // The counter stops once locked, so it never wraps while the flag is held.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      lockCnt <= '0;
      oLOCKED <= 1'b0;
    end else if (iARESET) begin
      lockCnt <= '0;
      oLOCKED <= 1'b0;
    end else if (!oLOCKED) begin
      lockCnt <= lockCnt + CNT_W'(1);
      if (lockCnt == CNT_W'(LOCK_CYCLES - 1)) begin
        oLOCKED <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/nco_clock_gen.sv
// NCO clock-enable generator: MUL enable pulses per DIV reference cycles once locked.
// Define NCO_CLK_OUT_EN to add the oC0 divided-clock output.
module nco_clock_gen
  import nco_clock_pkg::*;
#(
  parameter int MUL         = DISPLAY_MUL,
  parameter int DIV         = DISPLAY_DIV,
  parameter int LOCK_CYCLES = 16
) (
  input  logic            iCLOCK,
  input  logic            inRESET,
  nco_clock_gen_if.slave  bus
);

  localparam int ACC_W = accWidth(DIV);

  if (MUL < 1 || MUL > DIV || DIV < 2 || LOCK_CYCLES < 1) begin : gBadParams
    $error("nco_clock_gen: need 1 <= MUL <= DIV, DIV >= 2, LOCK_CYCLES >= 1");
  end

  logic             locked;
  logic             c0En;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;

  nco_lock_counter #(
    .LOCK_CYCLES(LOCK_CYCLES)
  ) lockCounter (
    .iCLOCK (iCLOCK),
    .inRESET(inRESET),
    .iARESET(bus.iARESET),
    .oLOCKED(locked)
  );

  // acc < DIV and MUL <= DIV keep sum below 2*DIV, which fits in ACC_W bits.
  assign sum = acc + ACC_W'(MUL);

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      acc  <= '0;
      c0En <= 1'b0;
    end else if (bus.iARESET || !locked) begin
      acc  <= '0;
      c0En <= 1'b0;
    end else if (sum >= ACC_W'(DIV)) begin
      acc  <= sum - ACC_W'(DIV);
      c0En <= 1'b1;
    end else begin
      acc  <= sum;
      c0En <= 1'b0;
    end
  end

  assign bus.oC0_EN  = c0En;
  assign bus.oLOCKED = locked;

`ifdef NCO_CLK_OUT_EN
  logic c0;

  // Toggling once per enable pulse yields a square wave at half the pulse rate.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      c0 <= 1'b0;
    end else if (bus.iARESET) begin
      c0 <= 1'b0;
    end else if (c0En) begin
      c0 <= ~c0;
    end
  end

  assign bus.oC0 = c0;
`endif

endmodule

// File: tb/tb_nco_clock_gen.sv
// Bench for nco_clock_gen: three instances (1/2, 63/125, 3072/3125) against an arithmetic reference model.
// Define NCO_CLK_OUT_EN to also check the oC0 divided-clock output.
module tb_nco_clock_gen;
  import nco_clock_pkg::*;

  typedef struct {
    logic arst;
    logic expEn;
    logic expLk;
  } vec_t;

  logic clk = 1'b0;
  logic rstN;
  logic arst [3];
  logic en   [3];
  logic lk   [3];
  int   checks;
  int   errors;
  longint cyc [3];
  int   maxAcc;

  always #5 clk = ~clk;

  nco_clock_gen_if ifA ();
  nco_clock_gen_if ifB ();
  nco_clock_gen_if ifC ();

  nco_clock_gen #(.MUL(1), .DIV(2), .LOCK_CYCLES(4)) dutA (
    .iCLOCK(clk), .inRESET(rstN), .bus(ifA)
  );
  nco_clock_gen #(.MUL(DISPLAY_MUL), .DIV(DISPLAY_DIV), .LOCK_CYCLES(16)) dutB (
    .iCLOCK(clk), .inRESET(rstN), .bus(ifB)
  );
  nco_clock_gen #(.MUL(DPS_MUL), .DIV(DPS_DIV), .LOCK_CYCLES(16)) dutC (
    .iCLOCK(clk), .inRESET(rstN), .bus(ifC)
  );

  assign ifA.iARESET = arst[0];
  assign ifB.iARESET = arst[1];
  assign ifC.iARESET = arst[2];
  assign en[0] = ifA.oC0_EN;
  assign en[1] = ifB.oC0_EN;
  assign en[2] = ifC.oC0_EN;
  assign lk[0] = ifA.oLOCKED;
  assign lk[1] = ifB.oLOCKED;
  assign lk[2] = ifC.oLOCKED;

`ifdef NCO_CLK_OUT_EN
  logic c0 [3];
  assign c0[0] = ifA.oC0;
  assign c0[1] = ifB.oC0;
  assign c0[2] = ifC.oC0;
`endif

  function automatic longint mulOf(input int i);
    return (i == 0) ? 64'd1 : (i == 1) ? 64'd63 : 64'd3072;
  endfunction

  function automatic longint divOf(input int i);
    return (i == 0) ? 64'd2 : (i == 1) ? 64'd125 : 64'd3125;
  endfunction

  function automatic longint lockOf(input int i);
    return (i == 0) ? 64'd4 : 64'd16;
  endfunction

  // Reference: after n locked edges the total pulse count is floor(n*MUL/DIV).
  function automatic logic modelLocked(input int i);
    return cyc[i] >= lockOf(i);
  endfunction

  function automatic logic modelEn(input int i);
    longint n;
    n = cyc[i] - lockOf(i);
    if (n < 1) return 1'b0;
    return ((n * mulOf(i)) / divOf(i)) != (((n - 1) * mulOf(i)) / divOf(i));
  endfunction

  function automatic logic modelC0(input int i);
    longint n;
    n = cyc[i] - lockOf(i);
    if (n < 1) return 1'b0;
    return 1'(((n - 1) * mulOf(i)) / divOf(i));
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("model lock%0d", i), lk[i], modelLocked(i));
      check($sformatf("model en%0d", i), en[i], modelEn(i));
`ifdef NCO_CLK_OUT_EN
      check($sformatf("model c0_%0d", i), c0[i], modelC0(i));
`endif
    end
    if (int'(dutC.acc) > maxAcc) maxAcc = int'(dutC.acc);
  endtask

  // One reference edge: advance the model on posedge, compare on the following negedge.
  task automatic applyStimulus();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!rstN || arst[i]) cyc[i] = 0;
      else cyc[i]++;
    end
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    vec_t vecs [17];
    logic [7:0] lkPat;
    logic [7:0] enPat;
    int cnt;
    int zeroPairs;
    logic prevEn;

    checks = 0;
    errors = 0;
    maxAcc = 0;
    rstN   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      arst[i] = 1'b0;
      cyc[i]  = 0;
    end

    lkPat = 8'b1111_1000;
    enPat = 8'b1010_0000;
    for (int k = 0; k < 8; k++) begin
      vecs[k]     = '{1'b0, enPat[k], lkPat[k]};
      vecs[9 + k] = '{1'b0, enPat[k], lkPat[k]};
    end
    vecs[8] = '{1'b1, 1'b0, 1'b0};

    #2;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset lock%0d", i), lk[i], 1'b0);
      check($sformatf("reset en%0d", i), en[i], 1'b0);
    end
    repeat (2) applyStimulus();
    rstN = 1'b1;

    // 1/2 ratio lock latency and alternating pulses, with one mid-stream restart.
    for (int k = 0; k < 17; k++) begin
      arst[0] = vecs[k].arst;
      applyStimulus();
      check($sformatf("vec%0d en", k), en[0], vecs[k].expEn);
      check($sformatf("vec%0d lock", k), lk[0], vecs[k].expLk);
    end
    arst[0] = 1'b0;

    // 63/125: every 125-cycle locked window holds exactly 63 pulses.
    for (int w = 0; w < 10; w++) begin
      cnt = 0;
      for (int c = 0; c < 125; c++) begin
        applyStimulus();
        if (en[1]) cnt++;
      end
      checkInt($sformatf("display window%0d pulses", w), cnt, 63);
    end

    // 3072/3125: pulse count, no two consecutive idle cycles, accumulator bound.
    cnt = 0;
    zeroPairs = 0;
    prevEn = 1'b1;
    for (int c = 0; c < 3125; c++) begin
      applyStimulus();
      if (en[2]) cnt++;
      if (!en[2] && !prevEn) zeroPairs++;
      prevEn = en[2];
    end
    checkInt("dps window pulses", cnt, 3072);
    checkInt("dps consecutive zeros", zeroPairs, 0);
    check("dps acc below DIV", maxAcc < 3125, 1'b1);

    // Asynchronous reset mid-window takes effect without a clock edge.
    repeat (7) applyStimulus();
    #2 rstN = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("async lock%0d", i), lk[i], 1'b0);
      check($sformatf("async en%0d", i), en[i], 1'b0);
    end
    repeat (2) applyStimulus();
    rstN = 1'b1;
    repeat (300) applyStimulus();

    // Single-cycle restart of the 63/125 instance: relock, first pulse at locked cycle 2.
    arst[1] = 1'b1;
    applyStimulus();
    check("arst lock drop", lk[1], 1'b0);
    arst[1] = 1'b0;
    repeat (16) applyStimulus();
    check("arst relock", lk[1], 1'b1);
    applyStimulus();
    check("arst locked cycle1 en", en[1], 1'b0);
    applyStimulus();
    check("arst locked cycle2 en", en[1], 1'b1);

    // Random restarts and resets, including both active at once.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) arst[i] = ($urandom_range(63) == 0);
      rstN = ($urandom_range(199) != 0);
      applyStimulus();
    end
    rstN = 1'b1;
    for (int i = 0; i < 3; i++) arst[i] = 1'b0;
    repeat (40) applyStimulus();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
